// File: rtl/pipe_addsub_pkg.sv
// Shared constants for the chunked pipelined adder/subtractor.
package pipe_addsub_pkg;
   localparam logic OP_ADD     = 1'b0;
   localparam logic OP_SUB     = 1'b1;
   localparam int   DEF_WIDTH  = 16;
   localparam int   DEF_STAGES = 2;
endpackage

// File: rtl/pipe_addsub_stage.sv
// One CW-bit chunk adder with its pipeline register; 1 cycle, holds everything while en=0.
module addsub_stage
   import pipe_addsub_pkg::*;
#(
   parameter int CW = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          en,
   input  logic          vld,
   input  logic [CW-1:0] a,
   input  logic [CW-1:0] b,
   input  logic          cin,
   output logic          q_vld,
   output logic [CW-1:0] q_sum,
   output logic          q_cout,
   output logic          q_cmsb
);

   logic [CW:0] full;

   assign full = {1'b0, a} + {1'b0, b} + {{CW{1'b0}}, cin};

   // Carry into the chunk MSB is recovered from the sum bit, which also works for CW=1.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q_vld  <= 1'b0;
         q_sum  <= '0;
         q_cout <= 1'b0;
         q_cmsb <= 1'b0;
      end else if (en) begin
         q_vld  <= vld;
         q_sum  <= full[CW-1:0];
         q_cout <= full[CW];
         q_cmsb <= full[CW-1] ^ a[CW-1] ^ b[CW-1];
      end
   end

endmodule

// File: rtl/pipe_addsub.sv
// Pipelined add/sub, chunk k summed in stage k; latency STAGES, one beat/cycle, global stall on output backpressure.
// PIPE_ADDSUB_SAT_EN: saturate sum on signed overflow instead of wrapping.
module pipe_addsub
   import pipe_addsub_pkg::*;
#(
   parameter int WIDTH  = DEF_WIDTH,
   parameter int STAGES = DEF_STAGES
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int CW = WIDTH / STAGES;

   if (WIDTH < 2 || STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_bad_cfg
      $error("pipe_addsub: WIDTH must be >= 2 and divisible by STAGES");
   end

   logic             en;
   logic             v_p  [0:STAGES];
   logic             c_p  [0:STAGES];
   logic [WIDTH-1:0] s_p  [0:STAGES];
   logic [WIDTH-1:0] a_p  [0:STAGES-1];
   logic [WIDTH-1:0] b_p  [0:STAGES-1];
   logic             cm_p [0:STAGES-1];
   logic [WIDTH-1:0] raw;
   logic [WIDTH-1:0] res;
   logic             cout_r;
   logic             ovf_r;

   assign in_ready = !(out_valid && !out_ready);
   assign en       = in_ready;

   // Subtract is A + ~B + 1, the +1 entering as the chunk-0 carry.
   assign v_p[0] = in_valid;
   assign c_p[0] = (op == OP_SUB);
   assign a_p[0] = a;
   assign b_p[0] = (op == OP_SUB) ? ~b : b;
   assign s_p[0] = '0;

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      localparam logic [WIDTH-1:0] MASK = WIDTH'({CW{1'b1}}) << (k * CW);

      logic [CW-1:0]    qs;
      logic             qv;
      logic             qc;
      logic             qm;
      logic [WIDTH-1:0] s_hold;

      addsub_stage #(.CW(CW)) u_stage (
         .clk    (clk),
         .rst_n  (rst_n),
         .en     (en),
         .vld    (v_p[k]),
         .a      (a_p[k][k*CW +: CW]),
         .b      (b_p[k][k*CW +: CW]),
         .cin    (c_p[k]),
         .q_vld  (qv),
         .q_sum  (qs),
         .q_cout (qc),
         .q_cmsb (qm)
      );

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n)
            s_hold <= '0;
         else if (en)
            s_hold <= s_p[k];
      end

      assign s_p[k+1] = (s_hold & ~MASK) | (WIDTH'(qs) << (k * CW));
      assign v_p[k+1] = qv;
      assign c_p[k+1] = qc;
      assign cm_p[k]  = qm;

      // Unprocessed operand chunks ride along to the next stage.
      if (k < STAGES - 1) begin : g_fwd
         logic [WIDTH-1:0] a_hold;
         logic [WIDTH-1:0] b_hold;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               a_hold <= '0;
               b_hold <= '0;
            end else if (en) begin
               a_hold <= a_p[k];
               b_hold <= b_p[k];
            end
         end

         assign a_p[k+1] = a_hold;
         assign b_p[k+1] = b_hold;
      end
   end

   assign raw    = s_p[STAGES];
   assign cout_r = c_p[STAGES];
   assign ovf_r  = cout_r ^ cm_p[STAGES-1];

`ifdef PIPE_ADDSUB_SAT_EN
   // On overflow the wrapped sign is the inverse of the true sign.
   assign res = !ovf_r         ? raw :
                raw[WIDTH-1]   ? {1'b0, {(WIDTH-1){1'b1}}} :
                                 {1'b1, {(WIDTH-1){1'b0}}};
`else
   assign res = raw;
`endif

   assign out_valid = v_p[STAGES];
   assign sum       = out_valid ? res : '0;
   assign cout      = out_valid & cout_r;
   assign ovf       = out_valid & ovf_r;

endmodule

// File: tb/tb_pipe_addsub.sv
// Directed bench for pipe_addsub at WIDTH=8, STAGES=2.
module tb_pipe_addsub;
   import pipe_addsub_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic       op;
   logic [7:0] a;
   logic [7:0] b;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] sum;
   logic       cout;
   logic       ovf;

   int tests = 0;
   int fails = 0;

`ifdef PIPE_ADDSUB_SAT_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   always #5 clk = ~clk;

   pipe_addsub #(.WIDTH(8), .STAGES(2)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .ovf       (ovf)
   );

   // Offers one beat on an idle pipe, then scrambles the inputs and waits for the result.
   task automatic send_one(input logic o, input logic [7:0] x, input logic [7:0] y,
                           output logic [7:0] s, output logic c, output logic v,
                           output int lat);
      int n;
      in_valid  = 1'b1;
      op        = o;
      a         = x;
      b         = y;
      out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      op       = ~o;
      a        = ~x;
      b        = 8'h5A;
      lat = 1;
      n   = 0;
      while (!out_valid && n < 10) begin
         @(posedge clk); #1;
         lat++;
         n++;
      end
      s = sum;
      c = cout;
      v = ovf;
   endtask

   task automatic test_reset();
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      op        = OP_ADD;
      a         = 8'h00;
      b         = 8'h00;
      #12;
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
      tests++; if (sum !== 8'h00)      begin fails++; $display("FAIL reset_sum got %h want 00", sum); end
      tests++; if (cout !== 1'b0)      begin fails++; $display("FAIL reset_cout got %b want 0", cout); end
      tests++; if (ovf !== 1'b0)       begin fails++; $display("FAIL reset_ovf got %b want 0", ovf); end
      tests++; if (in_ready !== 1'b1)  begin fails++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      tests++; if (in_ready !== 1'b1)  begin fails++; $display("FAIL post_reset_in_ready got %b want 1", in_ready); end
   endtask

   task automatic test_add();
      logic [7:0] ta [3];
      logic [7:0] tb [3];
      logic [7:0] es [3];
      logic       ec [3];
      logic       eo [3];
      logic [7:0] s;
      logic       c;
      logic       v;
      int         lat;
      ta = '{8'hD5, 8'h55, 8'h7F};
      tb = '{8'hAA, 8'hAA, 8'h01};
      es = '{SAT ? 8'h80 : 8'h7F, 8'hFF, SAT ? 8'h7F : 8'h80};
      ec = '{1'b1, 1'b0, 1'b0};
      eo = '{1'b1, 1'b0, 1'b1};
      for (int i = 0; i < 3; i++) begin
         send_one(OP_ADD, ta[i], tb[i], s, c, v, lat);
         tests++; if (lat !== 2)    begin fails++; $display("FAIL add[%0d]_latency got %0d want 2", i, lat); end
         tests++; if (s !== es[i])  begin fails++; $display("FAIL add[%0d]_sum got %h want %h", i, s, es[i]); end
         tests++; if (c !== ec[i])  begin fails++; $display("FAIL add[%0d]_cout got %b want %b", i, c, ec[i]); end
         tests++; if (v !== eo[i])  begin fails++; $display("FAIL add[%0d]_ovf got %b want %b", i, v, eo[i]); end
      end
      @(posedge clk); #1;
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL idle_out_valid got %b want 0", out_valid); end
      tests++; if (sum !== 8'h00 || cout !== 1'b0 || ovf !== 1'b0) begin
         fails++; $display("FAIL idle_outputs got sum=%h cout=%b ovf=%b want 00/0/0", sum, cout, ovf);
      end
   endtask

   task automatic test_sub();
      logic [7:0] ta [3];
      logic [7:0] tb [3];
      logic [7:0] es [3];
      logic       ec [3];
      logic       eo [3];
      logic [7:0] s;
      logic       c;
      logic       v;
      int         lat;
      ta = '{8'h80, 8'h00, 8'h05};
      tb = '{8'h01, 8'h01, 8'h03};
      es = '{SAT ? 8'h80 : 8'h7F, 8'hFF, 8'h02};
      ec = '{1'b1, 1'b0, 1'b1};
      eo = '{1'b1, 1'b0, 1'b0};
      for (int i = 0; i < 3; i++) begin
         send_one(OP_SUB, ta[i], tb[i], s, c, v, lat);
         tests++; if (lat !== 2)    begin fails++; $display("FAIL sub[%0d]_latency got %0d want 2", i, lat); end
         tests++; if (s !== es[i])  begin fails++; $display("FAIL sub[%0d]_sum got %h want %h", i, s, es[i]); end
         tests++; if (c !== ec[i])  begin fails++; $display("FAIL sub[%0d]_cout got %b want %b", i, c, ec[i]); end
         tests++; if (v !== eo[i])  begin fails++; $display("FAIL sub[%0d]_ovf got %b want %b", i, v, eo[i]); end
      end
      @(posedge clk); #1;
   endtask

   task automatic test_back_to_back();
      logic       to [4];
      logic [7:0] ta [4];
      logic [7:0] tb [4];
      logic [7:0] es [4];
      logic       ec [4];
      logic [7:0] held;
      int  sent = 0;
      int  rcv = 0;
      int  stall_left = 0;
      int  stalls = 0;
      int  cyc = 0;
      bit  stall_done = 1'b0;
      bit  acc;
      bit  emit;
      to = '{OP_ADD, OP_ADD, OP_SUB, OP_ADD};
      ta = '{8'h01, 8'h10, 8'h09, 8'hF0};
      tb = '{8'h02, 8'h20, 8'h04, 8'h20};
      es = '{8'h03, 8'h30, 8'h05, 8'h10};
      ec = '{1'b0, 1'b0, 1'b1, 1'b1};
      held = 8'h00;
      while (rcv < 4 && cyc < 40) begin
         if (!stall_done && out_valid) begin
            stall_left = 3;
            stall_done = 1'b1;
            held       = sum;
         end
         out_ready = (stall_left == 0);
         in_valid  = (sent < 4);
         if (sent < 4) begin
            op = to[sent];
            a  = ta[sent];
            b  = tb[sent];
         end
         @(negedge clk);
         acc  = in_valid && in_ready;
         emit = out_valid && out_ready;
         if (stall_left > 0) begin
            stalls++;
            tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL stall_in_ready cyc %0d got %b want 0", cyc, in_ready); end
            tests++; if (out_valid !== 1'b1 || sum !== held) begin
               fails++; $display("FAIL stall_hold cyc %0d got v=%b sum=%h want v=1 sum=%h", cyc, out_valid, sum, held);
            end
         end
         if (emit) begin
            tests++; if (sum !== es[rcv])  begin fails++; $display("FAIL b2b[%0d]_sum got %h want %h", rcv, sum, es[rcv]); end
            tests++; if (cout !== ec[rcv]) begin fails++; $display("FAIL b2b[%0d]_cout got %b want %b", rcv, cout, ec[rcv]); end
         end
         @(posedge clk); #1;
         if (acc) sent++;
         if (emit) rcv++;
         if (stall_left > 0) stall_left--;
         cyc++;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tests++; if (rcv !== 4)    begin fails++; $display("FAIL b2b_count got %0d want 4", rcv); end
      tests++; if (stalls !== 3) begin fails++; $display("FAIL b2b_stall_cycles got %0d want 3", stalls); end
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL b2b_no_extra got %b want 0", out_valid); end
   endtask

   task automatic test_reset_midflight();
      logic [7:0] s;
      logic       c;
      logic       v;
      int         lat;
      bit         stale = 1'b0;
      out_ready = 1'b1;
      in_valid  = 1'b1;
      op        = OP_ADD;
      a         = 8'h11;
      b         = 8'h22;
      @(posedge clk); #1;
      a = 8'h33;
      b = 8'h44;
      @(posedge clk); #1;
      in_valid = 1'b0;
      tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL inflight_out_valid got %b want 1", out_valid); end
      rst_n = 1'b0;
      #1;
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL midreset_out_valid got %b want 0", out_valid); end
      tests++; if (sum !== 8'h00)      begin fails++; $display("FAIL midreset_sum got %h want 00", sum); end
      tests++; if (cout !== 1'b0 || ovf !== 1'b0) begin fails++; $display("FAIL midreset_flags got %b%b want 00", cout, ovf); end
      tests++; if (in_ready !== 1'b1)  begin fails++; $display("FAIL midreset_in_ready got %b want 1", in_ready); end
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (4) begin
         @(posedge clk); #1;
         if (out_valid) stale = 1'b1;
      end
      tests++; if (stale !== 1'b0) begin fails++; $display("FAIL stale_after_reset got %b want 0", stale); end
      send_one(OP_ADD, 8'h12, 8'h34, s, c, v, lat);
      tests++; if (lat !== 2)    begin fails++; $display("FAIL post_reset_latency got %0d want 2", lat); end
      tests++; if (s !== 8'h46)  begin fails++; $display("FAIL post_reset_sum got %h want 46", s); end
      tests++; if (c !== 1'b0 || v !== 1'b0) begin fails++; $display("FAIL post_reset_flags got %b%b want 00", c, v); end
      @(posedge clk); #1;
   endtask

   initial begin
      test_reset();
      test_add();
      test_sub();
      test_back_to_back();
      test_reset_midflight();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
